// File: rtl/icache_dm_blocking_pkg.sv
// Shared system definitions for the instruction-cache slice: address width,
// memory-bus command encoding, bus transaction tag, cache entry layout and
// cache controller states.
package icache_dm_blocking_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef logic [3:0] MEM_TAG;

    // Widest tag any legal CACHE_LINES (>= 2) can need; narrower tags are
    // zero-extended into this field.
    localparam int ICACHE_TAG_W_MAX = XLEN - 4;

    typedef struct packed {
        logic [63:0]                 data;
        logic [ICACHE_TAG_W_MAX-1:0] tag;
        logic                        valid;
    } ICACHE_ENTRY;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_REQ,
        IC_WAIT
    } ICACHE_STATE;

endpackage

// File: rtl/icache_dm_blocking_mem.sv
// icache_mem: CACHE_LINES-deep line storage for the direct-mapped icache.
// One combinational read port, one synchronous write port. Only the valid
// bits are cleared by reset; data and tag arrays are left uninitialised.
module icache_mem
    import icache_dm_blocking_pkg::*;
#(
    parameter int   CACHE_LINES = 32,
    localparam int  IDX_W       = $clog2(CACHE_LINES)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [IDX_W-1:0]            rd_idx,
    output ICACHE_ENTRY                 rd_entry,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [63:0]                 wr_data,
    input  logic [ICACHE_TAG_W_MAX-1:0] wr_tag
);

    logic [63:0]                 data_q [CACHE_LINES];
    logic [ICACHE_TAG_W_MAX-1:0] tag_q  [CACHE_LINES];
    logic [CACHE_LINES-1:0]      valid_q;

    // Valid bits: cleared on reset, set when a line is filled.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Data and tag arrays: written on fill only, never reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            data_q[wr_idx] <= wr_data;
            tag_q[wr_idx]  <= wr_tag;
        end
    end

    // Read port returns current contents; a same-cycle write is seen next cycle.
    always_comb begin
        rd_entry.data  = data_q[rd_idx];
        rd_entry.tag   = tag_q[rd_idx];
        rd_entry.valid = valid_q[rd_idx];
    end

endmodule

// File: rtl/icache_dm_blocking.sv
// icache_dm_blocking: direct-mapped, read-only, blocking instruction cache.
// Hits are answered combinationally; a miss issues one BUS_LOAD, waits for
// the matching tagged return and fills the line. One miss outstanding.
// Optional macro ICACHE_FILL_BYPASS_EN forwards the returning line to the
// fetch port in the fill cycle when fetch is asking for that line.
module icache_dm_blocking
    import icache_dm_blocking_pkg::*;
#(
    parameter int CACHE_LINES = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] proc2Icache_addr,
    output logic [63:0]     Icache2proc_data,
    output logic            Icache2proc_data_valid,
    output logic [1:0]      proc2Imem_command,
    output logic [XLEN-1:0] proc2Imem_addr,
    input  logic [3:0]      Imem2proc_response,
    input  logic [63:0]     Imem2proc_data,
    input  logic [3:0]      Imem2proc_tag
);

    localparam int IDX_W = $clog2(CACHE_LINES);

    ICACHE_STATE                 state, state_n;
    logic [XLEN-1:0]             miss_addr, miss_addr_n;
    MEM_TAG                      pend_tag, pend_tag_n;
    BUS_COMMAND                  cmd;

    logic [IDX_W-1:0]            rd_idx, fill_idx;
    logic [ICACHE_TAG_W_MAX-1:0] rd_tag, fill_tag;
    ICACHE_ENTRY                 rd_entry;
    logic                        hit, fill, wr_en;
    logic                        unused_offset;

    assign unused_offset = ^proc2Icache_addr[2:0];

    assign rd_idx   = proc2Icache_addr[IDX_W+2:3];
    assign rd_tag   = ICACHE_TAG_W_MAX'(proc2Icache_addr[XLEN-1:IDX_W+3]);
    assign fill_idx = miss_addr[IDX_W+2:3];
    assign fill_tag = ICACHE_TAG_W_MAX'(miss_addr[XLEN-1:IDX_W+3]);

    assign hit   = rd_entry.valid && (rd_entry.tag == rd_tag);
    assign fill  = (state == IC_WAIT) && (pend_tag != '0) && (Imem2proc_tag == pend_tag);
    // A return arriving while reset is held must not touch the arrays.
    assign wr_en = fill && !reset;

    icache_mem #(
        .CACHE_LINES (CACHE_LINES)
    ) u_mem (
        .clock    (clock),
        .reset    (reset),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry),
        .wr_en    (wr_en),
        .wr_idx   (fill_idx),
        .wr_data  (Imem2proc_data),
        .wr_tag   (fill_tag)
    );

    // Controller state, latched miss line and outstanding bus tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IC_IDLE;
            miss_addr <= '0;
            pend_tag  <= '0;
        end else begin
            state     <= state_n;
            miss_addr <= miss_addr_n;
            pend_tag  <= pend_tag_n;
        end
    end

    // Next-state logic and bus command: new misses are only accepted in IDLE.
    always_comb begin
        state_n     = state;
        miss_addr_n = miss_addr;
        pend_tag_n  = pend_tag;
        cmd         = BUS_NONE;
        case (state)
            IC_IDLE: begin
                if (!hit) begin
                    miss_addr_n = {proc2Icache_addr[XLEN-1:3], 3'b000};
                    state_n     = IC_REQ;
                end
            end
            IC_REQ: begin
                cmd = BUS_LOAD;
                if (Imem2proc_response != '0) begin
                    pend_tag_n = Imem2proc_response;
                    state_n    = IC_WAIT;
                end
            end
            IC_WAIT: begin
                if (fill) begin
                    pend_tag_n = '0;
                    state_n    = IC_IDLE;
                end
            end
            default: state_n = IC_IDLE;
        endcase
    end

    // Fetch-side outputs and bus outputs, forced quiet while reset is held.
    always_comb begin
        Icache2proc_data       = rd_entry.data;
        Icache2proc_data_valid = hit;
`ifdef ICACHE_FILL_BYPASS_EN
        if (fill && (proc2Icache_addr[XLEN-1:3] == miss_addr[XLEN-1:3])) begin
            Icache2proc_data       = Imem2proc_data;
            Icache2proc_data_valid = 1'b1;
        end
`endif
        proc2Imem_command = cmd;
        proc2Imem_addr    = miss_addr;
        if (reset) begin
            Icache2proc_data_valid = 1'b0;
            proc2Imem_command      = BUS_NONE;
        end
    end

endmodule
